// File: rtl/read_buffer_pl.sv
// In-order read reorder buffer between a user read port and CCI.
// Requests take a slot tag; out-of-order responses are returned to the user in allocation order.
module read_buffer_pl #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int TAG_BITS    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    // user request
    input  logic                   rd_en,
    input  logic [ADDR_LMT-1:0]    rd_addr,
    input  logic [MDATA-1:0]       rd_mdata,
    output logic                   rd_ready,
    // CCI request
    output logic [ADDR_LMT-1:0]    rd_req_addr,
    output logic [MDATA-1:0]       rd_req_mdata,
    output logic                   rd_req_en,
    input  logic                   rd_req_almostfull,
    // CCI response
    input  logic                   rd_rsp_valid,
    input  logic [MDATA-1:0]       rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
    // user response / status
    output logic                   rd_valid,
    output logic [CACHE_WIDTH-1:0] rd_data,
    output logic [MDATA-1:0]       rd_mdata_o,
    output logic [TAG_BITS:0]      outstanding,
    output logic                   err
);

    localparam int unsigned       NSLOT  = 1 << TAG_BITS;
    localparam logic [TAG_BITS:0] C_FULL = {1'b1, {TAG_BITS{1'b0}}};

    logic [CACHE_WIDTH-1:0] r_data [NSLOT];
    logic [MDATA-1:0]       r_umd  [NSLOT];
    logic [NSLOT-1:0]       r_alloc;
    logic [NSLOT-1:0]       r_filled;
    logic [TAG_BITS-1:0]    r_head;
    logic [TAG_BITS-1:0]    r_tail;
    logic [TAG_BITS:0]      r_outstanding;
    logic                   r_err;
    logic                   r_req_en;
    logic [ADDR_LMT-1:0]    r_req_addr;
    logic [MDATA-1:0]       r_req_mdata;
    logic                   r_valid;
    logic [CACHE_WIDTH-1:0] r_rd_data;
    logic [MDATA-1:0]       r_rd_mdata;

    logic                   w_accept;
    logic                   w_deliver;
    logic                   w_rsp_ok;
    logic                   w_rsp_bad;
    logic [TAG_BITS-1:0]    w_rsp_tag;
    logic [NSLOT-1:0]       w_alloc_nxt;
    logic [NSLOT-1:0]       w_filled_nxt;
    logic                   w_unused_mdata_hi;

    assign rd_ready  = !rd_req_almostfull && (r_outstanding < C_FULL);
    assign w_accept  = rd_en && rd_ready;
    assign w_rsp_tag = rd_rsp_mdata[TAG_BITS-1:0];
    // A filled bit only ever sits on an allocated slot, so this alone gates delivery.
    assign w_deliver = r_filled[r_head];
    assign w_rsp_ok  = rd_rsp_valid && r_alloc[w_rsp_tag] && !r_filled[w_rsp_tag];
    assign w_rsp_bad = rd_rsp_valid && !w_rsp_ok;

    assign w_unused_mdata_hi = ^rd_rsp_mdata[MDATA-1:TAG_BITS];

    // Accept is applied last so a freshly allocated slot wins over a release of the same slot.
    always_comb begin
        w_alloc_nxt  = r_alloc;
        w_filled_nxt = r_filled;
        if (w_deliver) begin
            w_alloc_nxt[r_head]  = 1'b0;
            w_filled_nxt[r_head] = 1'b0;
        end
        if (w_rsp_ok)
            w_filled_nxt[w_rsp_tag] = 1'b1;
        if (w_accept)
            w_alloc_nxt[r_tail] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alloc       <= '0;
            r_filled      <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_req_en      <= 1'b0;
            r_req_addr    <= '0;
            r_req_mdata   <= '0;
            r_valid       <= 1'b0;
            r_rd_data     <= '0;
            r_rd_mdata    <= '0;
        end else begin
            r_alloc  <= w_alloc_nxt;
            r_filled <= w_filled_nxt;

            r_req_en <= w_accept;
            if (w_accept) begin
                r_req_addr  <= rd_addr;
                r_req_mdata <= {{(MDATA-TAG_BITS){1'b0}}, r_tail};
                r_tail      <= r_tail + TAG_BITS'(1);
            end

            r_valid <= w_deliver;
            if (w_deliver) begin
                r_rd_data  <= r_data[r_head];
                r_rd_mdata <= r_umd[r_head];
                r_head     <= r_head + TAG_BITS'(1);
            end

            if (w_rsp_bad)
                r_err <= 1'b1;

            case ({w_accept, w_deliver})
                2'b10:   r_outstanding <= r_outstanding + (TAG_BITS+1)'(1);
                2'b01:   r_outstanding <= r_outstanding - (TAG_BITS+1)'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Slot payload storage carries no reset; validity is tracked by r_alloc/r_filled.
    always_ff @(posedge clk) begin
        if (w_rsp_ok)
            r_data[w_rsp_tag] <= rd_rsp_data;
        if (w_accept)
            r_umd[r_tail] <= rd_mdata;
    end

    assign rd_req_en    = r_req_en;
    assign rd_req_addr  = r_req_addr;
    assign rd_req_mdata = r_req_mdata;
    assign rd_valid     = r_valid;
    assign rd_data      = r_rd_data;
    assign rd_mdata_o   = r_rd_mdata;
    assign outstanding  = r_outstanding;
    assign err          = r_err;

endmodule

// File: tb/tb_read_buffer_pl.sv
// Bench for read_buffer_pl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_read_buffer_pl;

    localparam int AW = 20;
    localparam int MW = 14;
    localparam int CW = 512;
    localparam int TB = 4;
    localparam int NS = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [MW-1:0] rd_mdata;
    logic          rd_ready;
    logic [AW-1:0] rd_req_addr;
    logic [MW-1:0] rd_req_mdata;
    logic          rd_req_en;
    logic          rd_req_almostfull;
    logic          rd_rsp_valid;
    logic [MW-1:0] rd_rsp_mdata;
    logic [CW-1:0] rd_rsp_data;
    logic          rd_valid;
    logic [CW-1:0] rd_data;
    logic [MW-1:0] rd_mdata_o;
    logic [TB:0]   outstanding;
    logic          err;

    read_buffer_pl #(
        .ADDR_LMT(AW), .MDATA(MW), .CACHE_WIDTH(CW), .TAG_BITS(TB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_mdata(rd_mdata), .rd_ready(rd_ready),
        .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
        .rd_req_almostfull(rd_req_almostfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_mdata_o(rd_mdata_o),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding reads in allocation order.
    typedef struct {
        logic [TB-1:0] tag;
        logic [MW-1:0] umd;
        bit            filled;
        logic [CW-1:0] data;
    } ent_t;

    ent_t          q[$];
    int            m_tail = 0;
    logic          m_err = 1'b0;
    logic          m_req_en = 1'b0;
    logic [AW-1:0] m_req_addr = '0;
    logic [MW-1:0] m_req_md = '0;
    logic          m_valid = 1'b0;
    logic [CW-1:0] m_data = '0;
    logic [MW-1:0] m_md = '0;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            q.delete();
            m_tail = 0; m_err = 1'b0; m_req_en = 1'b0; m_req_addr = '0; m_req_md = '0;
            m_valid = 1'b0; m_data = '0; m_md = '0;
        end else begin
            bit   dlv;
            bit   acc;
            int   fi;
            ent_t e;
            dlv = (q.size() > 0) && q[0].filled;
            acc = rd_en && !rd_req_almostfull && (q.size() < NS);
            fi  = -1;
            if (rd_rsp_valid) begin
                for (int i = 0; i < q.size(); i++)
                    if (q[i].tag == rd_rsp_mdata[TB-1:0]) fi = i;
                if (fi < 0 || q[fi].filled) begin
                    m_err = 1'b1;
                    fi = -1;
                end
            end
            if (fi >= 0) begin
                q[fi].filled = 1'b1;
                q[fi].data   = rd_rsp_data;
            end
            m_req_en = acc;
            if (acc) begin
                m_req_addr = rd_addr;
                m_req_md   = MW'(m_tail);
                e.tag = TB'(m_tail); e.umd = rd_mdata; e.filled = 1'b0; e.data = '0;
                q.push_back(e);
                m_tail = (m_tail + 1) % NS;
            end
            m_valid = dlv;
            if (dlv) begin
                m_data = q[0].data;
                m_md   = q[0].umd;
                void'(q.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("rd_ready",     rd_ready,     (!rd_req_almostfull && q.size() < NS));
            chk("rd_req_en",    rd_req_en,    m_req_en);
            chk("rd_req_addr",  rd_req_addr,  m_req_addr);
            chk("rd_req_mdata", rd_req_mdata, m_req_md);
            chk("rd_valid",     rd_valid,     m_valid);
            chk("rd_data",      rd_data,      m_data);
            chk("rd_mdata_o",   rd_mdata_o,   m_md);
            chk("outstanding",  outstanding,  CW'(q.size()));
            chk("err",          err,          m_err);
        end
    end

    function automatic logic [CW-1:0] pat(input int n);
        logic [31:0] w;
        w = 32'(n) * 32'h9E37_79B1 + 32'h0000_1357;
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        rd_en = 1'b0;
        rd_rsp_valid = 1'b0;
    endtask

    task automatic rsp(input int tag, input logic [CW-1:0] d);
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = MW'(tag);
        rd_rsp_data  = d;
    endtask

    task automatic do_reset();
        quiet();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        quiet();
        rd_req_almostfull = 1'b0;
        rd_addr = '0; rd_mdata = '0; rd_rsp_mdata = '0; rd_rsp_data = '0;
        tick();
        tick();
        chk("rst_valid", rd_valid, 0);
        chk("rst_req_en", rd_req_en, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", rd_ready, 1);
        reset_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // single read
        rd_en = 1'b1; rd_addr = 20'h00010; rd_mdata = 14'h2A;
        tick();
        rd_en = 1'b0;
        chk("t1_req_en", rd_req_en, 1);
        chk("t1_req_mdata", rd_req_mdata, 0);
        chk("t1_req_addr", rd_req_addr, 20'h00010);
        chk("t1_outstanding", outstanding, 1);
        tick();
        chk("t1_req_en_drop", rd_req_en, 0);
        rsp(0, {64{8'hAB}});
        tick();
        rd_rsp_valid = 1'b0;
        chk("t1_valid_early", rd_valid, 0);
        tick();
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", rd_data, {64{8'hAB}});
        chk("t1_mdata_o", rd_mdata_o, 14'h2A);
        chk("t1_outstanding0", outstanding, 0);
        tick();
        chk("t1_valid_drop", rd_valid, 0);

        // reorder, with an accept coinciding with the first delivery
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; rd_addr = AW'(32'h100 + i); rd_mdata = MW'(32'h10 + i);
            tick();
        end
        rd_en = 1'b0;
        rsp(2, pat(2)); tick();
        rsp(0, pat(0)); tick();
        chk("t2_valid_early", rd_valid, 0);
        rsp(1, pat(1));
        rd_en = 1'b1; rd_addr = 20'h00200; rd_mdata = 14'h13;
        tick();
        quiet();
        chk("t2_v0", rd_valid, 1);
        chk("t2_md0", rd_mdata_o, 14'h10);
        chk("t2_d0", rd_data, pat(0));
        chk("t2_out_same", outstanding, 3);
        chk("t2_req_md3", rd_req_mdata, 3);
        tick();
        chk("t2_v1", rd_valid, 1);
        chk("t2_md1", rd_mdata_o, 14'h11);
        chk("t2_d1", rd_data, pat(1));
        tick();
        chk("t2_v2", rd_valid, 1);
        chk("t2_md2", rd_mdata_o, 14'h12);
        chk("t2_d2", rd_data, pat(2));
        chk("t2_out1", outstanding, 1);
        tick();
        chk("t2_v_drop", rd_valid, 0);

        // full, ignored 17th request, duplicate response, tag wrap
        do_reset();
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = AW'(32'h300 + i); rd_mdata = MW'(32'h20 + i);
            tick();
        end
        chk("t3_out16", outstanding, 16);
        chk("t3_ready0", rd_ready, 0);
        rd_addr = 20'h003FF;
        tick();
        chk("t3_17th_ignored", rd_req_en, 0);
        chk("t3_out16b", outstanding, 16);
        rd_en = 1'b0;
        rsp(0, pat(40)); tick();
        rsp(0, pat(41)); tick();
        rd_rsp_valid = 1'b0;
        chk("t3_valid", rd_valid, 1);
        chk("t3_data", rd_data, pat(40));
        chk("t3_md", rd_mdata_o, 14'h20);
        chk("t3_out15", outstanding, 15);
        chk("t3_dup_err", err, 1);
        chk("t3_ready1", rd_ready, 1);
        rd_en = 1'b1; rd_addr = 20'h003AA; rd_mdata = 14'h3F;
        tick();
        rd_en = 1'b0;
        chk("t3_wrap_en", rd_req_en, 1);
        chk("t3_wrap_tag", rd_req_mdata, 0);
        chk("t3_out16c", outstanding, 16);

        // backpressure
        do_reset();
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = AW'(32'h400 + i); rd_mdata = MW'(32'h30 + i);
            tick();
        end
        rd_req_almostfull = 1'b1; rd_addr = 20'h004AA; rd_mdata = 14'h3A;
        #1;
        chk("t4_ready0", rd_ready, 0);
        tick();
        chk("t4_no_issue", rd_req_en, 0);
        chk("t4_out3", outstanding, 3);
        tick();
        rd_req_almostfull = 1'b0;
        #1;
        chk("t4_ready1", rd_ready, 1);
        tick();
        rd_en = 1'b0;
        chk("t4_issue", rd_req_en, 1);
        chk("t4_addr", rd_req_addr, 20'h004AA);
        chk("t4_tag", rd_req_mdata, 3);
        chk("t4_out4", outstanding, 4);

        // response to unallocated slot
        do_reset();
        rd_en = 1'b1; rd_addr = 20'h00500; rd_mdata = 14'h05;
        tick();
        rd_en = 1'b0;
        rsp(5, pat(5)); tick();
        rd_rsp_valid = 1'b0;
        chk("t5_err", err, 1);
        chk("t5_novalid", rd_valid, 0);
        tick();
        chk("t5_err_sticky", err, 1);
        chk("t5_out1", outstanding, 1);
        rsp(0, pat(50)); tick();
        quiet();
        tick();
        chk("t5_valid", rd_valid, 1);
        chk("t5_data", rd_data, pat(50));
        chk("t5_md", rd_mdata_o, 14'h05);
        chk("t5_err_still", err, 1);

        // reset mid-operation
        do_reset();
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_addr = AW'(32'h600 + i); rd_mdata = MW'(32'h40 + i);
            tick();
        end
        rd_en = 1'b0;
        rsp(0, pat(60)); tick();
        quiet(); tick();
        chk("t6_valid", rd_valid, 1);
        chk("t6_out4", outstanding, 4);
        rsp(15, pat(62)); tick();
        quiet();
        chk("t6_err_pre", err, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_out", outstanding, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_valid", rd_valid, 0);
        chk("t6_rst_req_en", rd_req_en, 0);
        chk("t6_rst_req_addr", rd_req_addr, 0);
        chk("t6_rst_req_md", rd_req_mdata, 0);
        chk("t6_rst_data", rd_data, 0);
        chk("t6_rst_mdo", rd_mdata_o, 0);
        tick();
        reset_n = 1'b1;
        tick();
        rsp(1, pat(61)); tick();
        quiet();
        chk("t6_stale_err", err, 1);
        tick();
        chk("t6_stale_novalid", rd_valid, 0);
        tick();
        chk("t6_stale_novalid2", rd_valid, 0);
        chk("t6_out0", outstanding, 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
